program_memory_loadable: RTL and testbench

//  Instruction memory for the accumulator CPU with a runtime load path. A fetch port serves the CPU

---
 rtl/program_memory_loadable_if.sv | 34 +++
 rtl/program_memory_loadable.sv | 139 +++++++++++++
 tb/tb_program_memory_loadable.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_loadable_if.sv
// program_memory_loadable_if
//   Bus between the accumulator CPU / UART bootloader (master) and the
//   loadable program memory (slave).
//   Fetch:  i_Addr, i_fetch_en -> o_Data, o_data_valid
//   Loader: i_load_start, i_load_end, i_byte, i_byte_valid
//           -> o_load_busy, o_load_done, o_word_count, o_overflow
interface program_memory_loadable_if #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int NBITS_B = 8
);
    logic [NBITS_O-1:0] i_Addr;
    logic               i_fetch_en;
    logic [NBITS_D-1:0] o_Data;
    logic               o_data_valid;
    logic               i_load_start;
    logic               i_load_end;
    logic [NBITS_B-1:0] i_byte;
    logic               i_byte_valid;
    logic               o_load_busy;
    logic               o_load_done;
    logic [NBITS_O:0]   o_word_count;
    logic               o_overflow;

    modport master (
        output i_Addr, i_fetch_en, i_load_start, i_load_end, i_byte, i_byte_valid,
        input  o_Data, o_data_valid, o_load_busy, o_load_done, o_word_count, o_overflow
    );

    modport slave (
        input  i_Addr, i_fetch_en, i_load_start, i_load_end, i_byte, i_byte_valid,
        output o_Data, o_data_valid, o_load_busy, o_load_done, o_word_count, o_overflow
    );
endinterface

// File: rtl/program_memory_loadable.sv
// program_memory_loadable
//   Instruction memory with a one-cycle synchronous fetch port and a
//   byte-serial loader that packs little-endian bytes into words and writes
//   them sequentially from address 0. Fetch is blocked while loading.
//   i_clk   : clock, rising edge
//   i_reset : synchronous, active-high
//   bus     : program_memory_loadable_if.slave (fetch + loader signals)
module program_memory_loadable #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int NBITS_B = 8,
    parameter int CELDAS  = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    program_memory_loadable_if.slave    bus
);
    localparam int BPW = NBITS_D / NBITS_B;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW  = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam logic [NBITS_O:0] DEPTH    = (NBITS_O + 1)'(CELDAS);
    localparam logic [IW-1:0]    LAST_IDX = IW'(BPW - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t             state_q, state_d;
    logic               clear, accept, finish;
    logic [IW-1:0]      idx_q;
    logic [NBITS_D-1:0] asm_q, word_full;
    logic [NBITS_O:0]   count_q;
    logic               ovf_q, done_q;
    logic [NBITS_D-1:0] data_q;
    logic               valid_q;
    logic               word_last, room;

    // Contents survive reset; zero (HALT) at configuration.
    logic [NBITS_D-1:0] mem [CELDAS] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Start outranks end; a byte arriving with start is dropped, a byte
    // arriving with end is still accepted.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_load_start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (bus.i_load_start) begin
                    clear = 1'b1;
                end else begin
                    accept = bus.i_byte_valid;
                    if (bus.i_load_end) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current byte merged into the assembly register at its lane.
    always_comb begin
        word_full = asm_q;
        for (int unsigned k = 0; k < BPW; k++) begin
            if (idx_q == IW'(k)) word_full[k*NBITS_B +: NBITS_B] = bus.i_byte;
        end
    end

    assign word_last = accept && (idx_q == LAST_IDX);
    assign room      = count_q < DEPTH;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_q   <= '0;
            asm_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (clear) begin
                idx_q   <= '0;
                asm_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (accept) begin
                if (idx_q == LAST_IDX) begin
                    idx_q <= '0;
                    asm_q <= '0;
                    if (room) count_q <= count_q + 1'b1;
                    else      ovf_q   <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    asm_q <= word_full;
                end
            end
            // Ending a load discards any partial word.
            if (finish) begin
                idx_q <= '0;
                asm_q <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && word_last && room) mem[count_q[AW-1:0]] <= word_full;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE && bus.i_fetch_en) begin
            valid_q <= 1'b1;
            data_q  <= ({1'b0, bus.i_Addr} < DEPTH) ? mem[bus.i_Addr[AW-1:0]] : '0;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_Data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_load_busy  = (state_q == LOAD);
    assign bus.o_load_done  = done_q;
    assign bus.o_word_count = count_q;
    assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_program_memory_loadable.sv
// tb_program_memory_loadable
//   Self-checking bench for program_memory_loadable (small 4-word config).
//   The reference model packs byte lists into words directly and tracks
//   memory contents, word count and overflow per load.
module tb_program_memory_loadable;
    localparam int NO  = 3;
    localparam int ND  = 16;
    localparam int NB  = 8;
    localparam int CEL = 4;
    localparam int BPW = ND / NB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_memory_loadable_if #(.NBITS_O(NO), .NBITS_D(ND), .NBITS_B(NB)) bus ();

    program_memory_loadable #(
        .NBITS_O(NO), .NBITS_D(ND), .NBITS_B(NB), .CELDAS(CEL)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [ND-1:0] mdl_mem [CEL];
    int            mdl_count;
    bit            mdl_ovf;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [NB-1:0] q[$]);
        logic [ND-1:0] w;
        mdl_count = 0;
        mdl_ovf   = 1'b0;
        for (int n = 0; (n + 1) * BPW <= q.size(); n++) begin
            w = '0;
            for (int b = 0; b < BPW; b++) w[b*NB +: NB] = q[n*BPW + b];
            if (mdl_count < CEL) begin
                mdl_mem[mdl_count] = w;
                mdl_count++;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive_load(input logic [NB-1:0] q[$], input bit end_on_last);
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        foreach (q[i]) begin
            repeat ($urandom_range(0, 2)) step();
            bus.i_byte       = q[i];
            bus.i_byte_valid = 1'b1;
            if (end_on_last && i == q.size() - 1) bus.i_load_end = 1'b1;
            step();
            bus.i_byte_valid = 1'b0;
            bus.i_byte       = NB'($urandom);
        end
        if (!(end_on_last && q.size() > 0)) begin
            bus.i_load_end = 1'b1;
            step();
        end
        bus.i_load_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.o_Data !== '0 || bus.o_data_valid !== 1'b0 || bus.o_load_busy !== 1'b0 ||
            bus.o_load_done !== 1'b0 || bus.o_word_count !== '0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: data=%h valid=%b busy=%b done=%b count=%0d ovf=%b, required all zero",
                     bus.o_Data, bus.o_data_valid, bus.o_load_busy, bus.o_load_done,
                     bus.o_word_count, bus.o_overflow);
        end
        rst = 1'b0;
        step();
    endtask

    // Descending sweep so the final held value comes from address 0.
    task automatic test_fetch_sweep(input string name);
        logic [ND-1:0] exp;
        int a;
        exp = '0;
        for (int i = 0; i < (1 << NO); i++) begin
            a = (1 << NO) - 1 - i;
            bus.i_Addr     = NO'(a);
            bus.i_fetch_en = 1'b1;
            step();
            exp = (a < CEL) ? mdl_mem[a] : '0;
            checks++;
            if (bus.o_Data !== exp || bus.o_data_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s fetch addr %0d: data=%h valid=%b, required data=%h valid=1",
                         name, a, bus.o_Data, bus.o_data_valid, exp);
            end
        end
        bus.i_fetch_en = 1'b0;
        bus.i_Addr     = NO'($urandom);
        step();
        checks++;
        if (bus.o_Data !== exp || bus.o_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s fetch hold: data=%h valid=%b, required data=%h valid=0",
                     name, bus.o_Data, bus.o_data_valid, exp);
        end
    endtask

    task automatic test_load(input string name, input logic [NB-1:0] q[$], input bit end_on_last);
        drive_load(q, end_on_last);
        model_load(q);
        checks++;
        if (bus.o_load_done !== 1'b1 || bus.o_load_busy !== 1'b0 ||
            bus.o_word_count !== (NO+1)'(mdl_count) || bus.o_overflow !== mdl_ovf) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b count=%0d ovf=%b, required done=1 busy=0 count=%0d ovf=%b",
                     name, bus.o_load_done, bus.o_load_busy, bus.o_word_count, bus.o_overflow,
                     mdl_count, mdl_ovf);
        end
        step();
        checks++;
        if (bus.o_load_done !== 1'b0 || bus.o_word_count !== (NO+1)'(mdl_count)) begin
            errors++;
            $display("FAIL %s after: done=%b count=%0d, required done=0 count=%0d",
                     name, bus.o_load_done, bus.o_word_count, mdl_count);
        end
        test_fetch_sweep(name);
    endtask

    task automatic test_idle_ignored();
        repeat (3) begin
            bus.i_byte       = NB'($urandom);
            bus.i_byte_valid = 1'b1;
            bus.i_load_end   = 1'b1;
            step();
        end
        bus.i_byte_valid = 1'b0;
        bus.i_load_end   = 1'b0;
        checks++;
        if (bus.o_load_busy !== 1'b0 || bus.o_load_done !== 1'b0 ||
            bus.o_word_count !== (NO+1)'(mdl_count)) begin
            errors++;
            $display("FAIL idle_ignored: busy=%b done=%b count=%0d, required 0 0 %0d",
                     bus.o_load_busy, bus.o_load_done, bus.o_word_count, mdl_count);
        end
        test_fetch_sweep("idle_ignored");
    endtask

    task automatic test_fetch_blocked();
        logic [NB-1:0] q[$];
        logic [ND-1:0] held;
        bus.i_Addr     = '0;
        bus.i_fetch_en = 1'b1;
        step();
        held = mdl_mem[0];
        bus.i_fetch_en   = 1'b0;
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            q.push_back(NB'($urandom));
            bus.i_byte       = q[i];
            bus.i_byte_valid = 1'b1;
            bus.i_fetch_en   = 1'b1;
            bus.i_Addr       = NO'($urandom);
            step();
            checks++;
            if (bus.o_data_valid !== 1'b0 || bus.o_Data !== held || bus.o_load_busy !== 1'b1) begin
                errors++;
                $display("FAIL fetch_blocked: valid=%b data=%h busy=%b, required valid=0 data=%h busy=1",
                         bus.o_data_valid, bus.o_Data, bus.o_load_busy, held);
            end
        end
        bus.i_byte_valid = 1'b0;
        bus.i_fetch_en   = 1'b0;
        bus.i_load_end   = 1'b1;
        step();
        bus.i_load_end = 1'b0;
        model_load(q);
        bus.i_Addr     = NO'(CEL);
        bus.i_fetch_en = 1'b1;
        step();
        bus.i_fetch_en = 1'b0;
        checks++;
        if (bus.o_Data !== '0 || bus.o_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_out_of_range: data=%h valid=%b, required data=0000 valid=1",
                     bus.o_Data, bus.o_data_valid);
        end
        test_fetch_sweep("fetch_blocked");
    endtask

    task automatic test_restart();
        logic [NB-1:0] q1[$] = '{8'haa, 8'hbb, 8'hcc};
        logic [NB-1:0] q2[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        foreach (q1[i]) begin
            bus.i_byte = q1[i]; bus.i_byte_valid = 1'b1;
            step();
        end
        // Restart with a byte pending: that byte must be dropped.
        bus.i_byte = 8'hdd; bus.i_load_start = 1'b1; bus.i_load_end = 1'b1;
        step();
        bus.i_load_start = 1'b0; bus.i_load_end = 1'b0;
        checks++;
        if (bus.o_word_count !== '0 || bus.o_load_busy !== 1'b1 || bus.o_load_done !== 1'b0) begin
            errors++;
            $display("FAIL restart clear: count=%0d busy=%b done=%b, required 0 1 0",
                     bus.o_word_count, bus.o_load_busy, bus.o_load_done);
        end
        foreach (q2[i]) begin
            bus.i_byte = q2[i]; bus.i_byte_valid = 1'b1;
            step();
        end
        bus.i_byte_valid = 1'b0;
        bus.i_load_end   = 1'b1;
        step();
        bus.i_load_end = 1'b0;
        model_load(q1[0:1]);
        model_load(q2);
        checks++;
        if (bus.o_word_count !== (NO+1)'(mdl_count) || bus.o_load_done !== 1'b1) begin
            errors++;
            $display("FAIL restart end: count=%0d done=%b, required count=%0d done=1",
                     bus.o_word_count, bus.o_load_done, mdl_count);
        end
        step();
        test_fetch_sweep("restart");
    endtask

    task automatic test_reset_midload();
        logic [NB-1:0] q[$];
        for (int i = 0; i < 7; i++) q.push_back(NB'($urandom));
        bus.i_load_start = 1'b1;
        step();
        bus.i_load_start = 1'b0;
        foreach (q[i]) begin
            bus.i_byte = q[i]; bus.i_byte_valid = 1'b1;
            step();
        end
        bus.i_byte_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_load(q[0:5]);
        mdl_count = 0;
        mdl_ovf   = 1'b0;
        checks++;
        if (bus.o_load_busy !== 1'b0 || bus.o_word_count !== '0 || bus.o_overflow !== 1'b0 ||
            bus.o_load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload: busy=%b count=%0d ovf=%b done=%b, required all zero",
                     bus.o_load_busy, bus.o_word_count, bus.o_overflow, bus.o_load_done);
        end
        test_fetch_sweep("reset_midload");
    endtask

    task automatic test_random_loads();
        logic [NB-1:0] q[$];
        for (int n = 0; n < 8; n++) begin
            q.delete();
            repeat ($urandom_range(0, 11)) q.push_back(NB'($urandom));
            test_load("random", q, 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_Addr = '0; bus.i_fetch_en = 1'b0;
        bus.i_load_start = 1'b0; bus.i_load_end = 1'b0;
        bus.i_byte = '0; bus.i_byte_valid = 1'b0;
        for (int i = 0; i < CEL; i++) mdl_mem[i] = '0;
        mdl_count = 0;
        mdl_ovf   = 1'b0;

        test_reset();
        test_fetch_sweep("power_up");
        test_load("two_words", '{8'h01, 8'h10, 8'h02, 8'h28}, 1'b0);
        test_load("partial", '{8'h34, 8'h12, 8'h56}, 1'b0);
        test_idle_ignored();
        test_load("overflow", '{8'h01, 8'ha1, 8'h02, 8'hb2, 8'h03, 8'hc3,
                                8'h04, 8'hd4, 8'h05, 8'he5}, 1'b0);
        test_fetch_blocked();
        test_reset_midload();
        test_load("end_with_last", '{8'h78, 8'h56, 8'hbc, 8'h9a}, 1'b1);
        test_restart();
        test_random_loads();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
